bcd_scan_mux: RTL and testbench
===============================

BCD_SCAN_MUX -- requirements
Module: bcd_scan_mux

Interface
- REQ-001: The block SHALL have parameter PRESCALE, default 4, giving clock cycles per digit slot (legal 1..65535).
- REQ-002: The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-003: The block SHALL have port rst, input, 1 bit: reset; one clock, reset synchronous and active-high.
- REQ-004: The block SHALL have port load, input, 1 bit: capture din/lzb_in on this edge.
- REQ-005: The block SHALL have port din, input, 16 bits: four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- REQ-006: The block SHALL have port lzb_in, input, 1 bit: leading-zero-blank enable, captured with load.
- REQ-007: The block SHALL have ports w, x, y, z, outputs, 1 bit each: current digit nibble to the 7-segment decoder, w = MSB.
- REQ-008: The block SHALL have port an, output, 4 bits: one-hot active-high digit enable, an[i] = digit i.
- REQ-009: The block SHALL have port blank, output, 1 bit: high when the current slot is blanked.
- REQ-010: The block SHALL have port err, output, 1 bit: high when the current slot's nibble > 9.
- REQ-011: The block SHALL have port frame, output, 1 bit: high in the first cycle of each frame.

Function
- REQ-012: The block SHALL hold these state registers: prescaler pre (0..PRESCALE-1), digit index idx (0..3), active[15:0], active_lzb, pending[15:0], pending_lzb, pending_valid.
- REQ-013: pre SHALL increment each cycle; at PRESCALE-1 it SHALL wrap to 0 and idx SHALL advance 0→1→2→3→0.
- REQ-014: With PRESCALE=1, idx SHALL advance every cycle.
- REQ-015: All outputs SHALL be combinational functions of registered state only, giving zero added latency after a state edge and no dependence on inputs.
- REQ-016: {w,x,y,z} SHALL equal active[4*idx+3:4*idx] when the slot is not blanked; an SHALL equal 1<<idx.
- REQ-017: A slot SHALL be blanked iff active_lzb=1, idx>0, and active digits idx..3 are all zero; digit 0 SHALL never be blanked.
- REQ-018: In a blanked slot: an=0000, {w,x,y,z}=0000, blank=1, err=0.
- REQ-019: err SHALL be 1 iff the slot is not blanked and the displayed nibble is in 10..15; the nibble SHALL still pass through unmodified.
- REQ-020: frame SHALL be 1 iff idx=0 and pre=0.
- REQ-021: On a load edge, pending←din, pending_lzb←lzb_in, pending_valid←1; a later load before transfer SHALL overwrite pending (last load wins).
- REQ-022: Transfer SHALL occur only on the frame-wrap edge (idx=3, pre=PRESCALE-1); there, if pending_valid, active←pending, active_lzb←pending_lzb, pending_valid←0. Frames are therefore never torn.
- REQ-023: When load coincides with the wrap edge, din/lzb_in SHALL go directly to active/active_lzb and pending_valid SHALL clear (newest data wins).
- REQ-024: When no load is pending, active SHALL hold indefinitely.

Reset
- REQ-025: When rst is sampled high, the block SHALL set pre=0, idx=0, active=0, active_lzb=0, pending=0, pending_lzb=0, pending_valid=0, overriding load on the same edge.
- REQ-026: Outputs in the cycle after reset SHALL be: an=0001, wxyz=0000, blank=0, err=0, frame=1.
- REQ-027: Reset asserted mid-frame or with a load pending SHALL discard all display data and pending data.

Verification (PRESCALE=4)
- REQ-028: Reset: pulse rst 1 cycle at idx=2 after loading 0x9999 → next cycle an=0001, wxyz=0000, frame=1, blank=0, err=0; 0x9999 never displayed.
- REQ-029: Scan: load din=0x1234, lzb_in=0 at frame start → current frame shows 0; after wrap, wxyz=4/an=0001, 3/0010, 2/0100, 1/1000, each held exactly 4 cycles; frame high 1 cycle per 16.
- REQ-030: Blanking: load 0x0042, lzb_in=1 → slots 3 and 2 give an=0000, blank=1; slots 1 and 0 show 4 and 2. Load 0x0000, lzb_in=1 → only slot 0 shows 0.
- REQ-031: Last load wins: load 0x1111, then 0x2222 two cycles later, same frame → next frame shows all 2s; 1s never appear.
- REQ-032: Wrap coincidence: load 0x5678 on the wrap edge with 0x1111 pending → next frame shows 0x5678; following frame unchanged.
- REQ-033: Invalid digit: load 0x00A0, lzb_in=0 → slot 1 gives wxyz=1010, err=1; other slots err=0.

Source files
------------

// File: rtl/bcd_scan_mux.sv
// Four-digit BCD scan multiplexer with leading-zero blanking and
// frame-synchronous double-buffered loading.
module bcd_scan_mux #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        lzb_in,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [3:0]  an,
  output logic        blank,
  output logic        err,
  output logic        frame
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre;
  logic [1:0]  idx;
  logic [15:0] active;
  logic        active_lzb;
  logic [15:0] pending;
  logic        pending_lzb;
  logic        pending_valid;

  logic        slot_end;
  logic        frame_wrap;
  logic [3:0]  nibble;
  logic        upper_zero;
  logic        blanked;

  assign slot_end   = (pre == PRE_MAX);
  assign frame_wrap = slot_end && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre           <= '0;
      idx           <= '0;
      active        <= '0;
      active_lzb    <= 1'b0;
      pending       <= '0;
      pending_lzb   <= 1'b0;
      pending_valid <= 1'b0;
    end else begin
      pre <= slot_end ? '0 : pre + 16'd1;
      if (slot_end) idx <= idx + 2'd1;

      // Display data only changes on the frame-wrap edge; a load landing
      // on that edge bypasses the pending buffer so the newest data wins.
      if (frame_wrap) begin
        if (load) begin
          active     <= din;
          active_lzb <= lzb_in;
        end else if (pending_valid) begin
          active     <= pending;
          active_lzb <= pending_lzb;
        end
        pending_valid <= 1'b0;
      end else if (load) begin
        pending       <= din;
        pending_lzb   <= lzb_in;
        pending_valid <= 1'b1;
      end
    end
  end

  // upper_zero: digits idx..3 are all zero; never true for digit 0.
  always_comb begin
    nibble     = active[3:0];
    upper_zero = 1'b0;
    case (idx)
      2'd0: begin
        nibble     = active[3:0];
        upper_zero = 1'b0;
      end
      2'd1: begin
        nibble     = active[7:4];
        upper_zero = (active[15:4] == 12'd0);
      end
      2'd2: begin
        nibble     = active[11:8];
        upper_zero = (active[15:8] == 8'd0);
      end
      default: begin
        nibble     = active[15:12];
        upper_zero = (active[15:12] == 4'd0);
      end
    endcase
  end

  assign blanked      = active_lzb && upper_zero;
  assign {w, x, y, z} = blanked ? 4'b0000 : nibble;
  assign an           = blanked ? 4'b0000 : (4'b0001 << idx);
  assign blank        = blanked;
  assign err          = !blanked && (nibble > 4'd9);
  assign frame        = (idx == 2'd0) && (pre == 16'd0);

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed self-checking bench for bcd_scan_mux at PRESCALE=4
// (16-cycle frames, 4 cycles per digit slot).
module tb_bcd_scan_mux;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic        lzb_in;
  logic        w, x, y, z;
  logic [3:0]  an;
  logic        blank;
  logic        err;
  logic        frame;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_scan_mux #(.PRESCALE(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .din    (din),
    .lzb_in (lzb_in),
    .w      (w),
    .x      (x),
    .y      (y),
    .z      (z),
    .an     (an),
    .blank  (blank),
    .err    (err),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc %0d: got %h expected %h", tag, c, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int c, input logic [3:0] e_an, input logic [3:0] e_n,
                         input logic e_blank, input logic e_err, input logic e_frame);
    chk({tag, ".an"},    c, an, e_an);
    chk({tag, ".wxyz"},  c, {w, x, y, z}, e_n);
    chk({tag, ".blank"}, c, 4'(blank), 4'(e_blank));
    chk({tag, ".err"},   c, 4'(err), 4'(e_err));
    chk({tag, ".frame"}, c, 4'(frame), 4'(e_frame));
  endtask

  // Checks one full frame starting at idx=0/pre=0. exp_d holds the
  // hand-computed digits, shown marks unblanked slots, errm the err slots.
  // Up to two loads (la, lb = cycle in frame, -1 for none) are issued.
  task automatic run_frame(input string tag, input logic [15:0] exp_d, input logic [3:0] shown,
                           input logic [3:0] errm,
                           input int la, input logic [15:0] da, input logic lza,
                           input int lb, input logic [15:0] db, input logic lzb_b);
    int i;
    logic [3:0] e_an;
    logic [3:0] e_n;
    for (int c = 0; c < 16; c++) begin
      i    = c / 4;
      e_an = shown[i] ? 4'(1 << i) : 4'b0000;
      e_n  = shown[i] ? exp_d[4*i +: 4] : 4'b0000;
      chk_all(tag, c, e_an, e_n, !shown[i], errm[i], (c == 0));
      load   = (c == la) || (c == lb);
      din    = (c == lb) ? db : da;
      lzb_in = (c == lb) ? lzb_b : lza;
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    load   = 1'b1;
    din    = 16'h7777;
    lzb_in = 1'b1;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    chk_all("reset0", -1, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b1);

    // Load at frame start: current frame still shows zeros.
    run_frame("scan_pre", 16'h0000, 4'b1111, 4'b0000, 0, 16'h1234, 1'b0, -1, 16'h0, 1'b0);
    run_frame("scan",     16'h1234, 4'b1111, 4'b0000, 0, 16'h0042, 1'b1, -1, 16'h0, 1'b0);
    run_frame("lzb42",    16'h0042, 4'b0011, 4'b0000, 0, 16'h0000, 1'b1, -1, 16'h0, 1'b0);
    run_frame("lzb00",    16'h0000, 4'b0001, 4'b0000, 3, 16'h1111, 1'b0, 5, 16'h2222, 1'b0);
    run_frame("lastwin",  16'h2222, 4'b1111, 4'b0000, 4, 16'h1111, 1'b0, 15, 16'h5678, 1'b0);
    run_frame("wrapld",   16'h5678, 4'b1111, 4'b0000, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
    run_frame("wraphold", 16'h5678, 4'b1111, 4'b0000, 7, 16'h00A0, 1'b0, -1, 16'h0, 1'b0);
    run_frame("baddig",   16'h00A0, 4'b1111, 4'b0010, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

    // Load 0x9999, then reset at idx=2 before it can transfer.
    load   = 1'b1;
    din    = 16'h9999;
    lzb_in = 1'b0;
    tick();
    load = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk_all("pre_rst", 8, 4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("reset1", -1, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b1);
    run_frame("post_rst0", 16'h0000, 4'b1111, 4'b0000, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
    run_frame("post_rst1", 16'h0000, 4'b1111, 4'b0000, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
